// File: rtl/fft_peak_detector_if.sv
// rtl/fft_peak_detector_if.sv - bin stream in, per-frame peak/energy result out
interface fft_peak_detector_if #(
  parameter int LOG2N = 6
);
  logic               i_data_valid;
  logic [31:0]        i_data;
  logic               o_data_ready;
  logic               o_data_valid;
  logic [LOG2N-1:0]   o_peak_bin;
  logic [31:0]        o_peak_mag;
  logic [31+LOG2N:0]  o_energy;
  logic               i_data_ready;

  modport slave (
    input  i_data_valid, i_data, i_data_ready,
    output o_data_ready, o_data_valid, o_peak_bin, o_peak_mag, o_energy
  );

  modport master (
    output i_data_valid, i_data, i_data_ready,
    input  o_data_ready, o_data_valid, o_peak_bin, o_peak_mag, o_energy
  );
endinterface

// File: rtl/fft_peak_detector.sv
// rtl/fft_peak_detector.sv - per-frame |X|^2 peak search and energy sum over FFT bins
module fft_peak_detector #(
  parameter int LOG2N   = 6,
  parameter bit SKIP_DC = 1'b0
) (
  input logic               i_clk,
  input logic               i_rst,
  fft_peak_detector_if.slave bus
);
  localparam int EW = 32 + LOG2N;

  typedef enum logic [1:0] {ACCUM, DRAIN, RESULT} state_t;
  state_t state, state_nxt;

  logic               xfer;
  logic               load_result;
  logic [LOG2N-1:0]   bin_cnt;

  logic               s1_valid;
  logic               s1_last;
  logic [LOG2N-1:0]   s1_bin;
  logic [31:0]        s1_re_sq;
  logic [31:0]        s1_im_sq;
  logic               s2_last;
  logic               s3_done;

  logic [31:0]        peak_mag;
  logic [LOG2N-1:0]   peak_bin;
  logic [EW-1:0]      energy;

  logic signed [15:0] re;
  logic signed [15:0] im;
  logic signed [31:0] re_prod;
  logic signed [31:0] im_prod;
  logic [31:0]        mag;

  assign re      = bus.i_data[31:16];
  assign im      = bus.i_data[15:0];
  assign re_prod = 32'(re) * 32'(re);
  assign im_prod = 32'(im) * 32'(im);
  // Each square is at most 2^30, so the sum fits 32 bits unsigned.
  assign mag     = s1_re_sq + s1_im_sq;

  assign bus.o_data_ready = (state == ACCUM) && !i_rst;
  assign bus.o_data_valid = (state == RESULT) && !i_rst;
  assign xfer             = bus.i_data_valid && bus.o_data_ready;

  always_ff @(posedge i_clk) begin
    if (i_rst) state <= ACCUM;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    load_result = 1'b0;
    case (state)
      ACCUM:   if (xfer && bin_cnt == '1) state_nxt = DRAIN;
      DRAIN: begin
        if (s3_done) begin
          load_result = 1'b1;
          state_nxt   = RESULT;
        end
      end
      RESULT:  if (bus.i_data_ready) state_nxt = ACCUM;
      default: state_nxt = ACCUM;
    endcase
  end

  // s2_last/s3_done walk the last bin's marker past the accumulator update,
  // giving the fixed three-edge result latency.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      bin_cnt  <= '0;
      s1_valid <= 1'b0;
      s1_last  <= 1'b0;
      s1_bin   <= '0;
      s1_re_sq <= '0;
      s1_im_sq <= '0;
      s2_last  <= 1'b0;
      s3_done  <= 1'b0;
    end else begin
      s1_valid <= xfer;
      if (xfer) begin
        bin_cnt  <= bin_cnt + LOG2N'(1);
        s1_bin   <= bin_cnt;
        s1_last  <= (bin_cnt == '1);
        s1_re_sq <= re_prod;
        s1_im_sq <= im_prod;
      end
      s2_last <= s1_valid && s1_last;
      s3_done <= s2_last;
    end
  end

  // Bin 0 reloads the accumulators so no clear step is needed between frames.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      peak_mag <= '0;
      peak_bin <= '0;
      energy   <= '0;
    end else if (s1_valid) begin
      if (s1_bin == '0) begin
        energy   <= EW'(mag);
        peak_mag <= SKIP_DC ? 32'd0 : mag;
        peak_bin <= '0;
      end else begin
        energy <= energy + EW'(mag);
        if (mag > peak_mag) begin
          peak_mag <= mag;
          peak_bin <= s1_bin;
        end
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      bus.o_peak_bin <= '0;
      bus.o_peak_mag <= '0;
      bus.o_energy   <= '0;
    end else if (load_result) begin
      bus.o_peak_bin <= peak_bin;
      bus.o_peak_mag <= peak_mag;
      bus.o_energy   <= energy;
    end
  end
endmodule

// File: tb/tb_fft_peak_detector.sv
// tb/tb_fft_peak_detector.sv - bench for fft_peak_detector, SKIP_DC=0 and SKIP_DC=1 side by side
module tb_fft_peak_detector;
  localparam int LOG2N = 6;
  localparam int N     = 1 << LOG2N;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fft_peak_detector_if #(.LOG2N(LOG2N)) bus0 ();
  fft_peak_detector_if #(.LOG2N(LOG2N)) bus1 ();

  fft_peak_detector #(.LOG2N(LOG2N), .SKIP_DC(1'b0)) u_dut0 (.i_clk(clk), .i_rst(rst), .bus(bus0));
  fft_peak_detector #(.LOG2N(LOG2N), .SKIP_DC(1'b1)) u_dut1 (.i_clk(clk), .i_rst(rst), .bus(bus1));

  int          n_cmp = 0;
  int          n_err = 0;
  int          fr_re [N];
  int          fr_im [N];
  logic [31:0] nxt0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] d);
    bus0.i_data_valid = v;
    bus0.i_data       = d;
    bus1.i_data_valid = v;
    bus1.i_data       = d;
  endtask

  task automatic set_ready(input logic r);
    bus0.i_data_ready = r;
    bus1.i_data_ready = r;
  endtask

  task automatic fill(input int re, input int im);
    for (int b = 0; b < N; b++) begin
      fr_re[b] = re;
      fr_im[b] = im;
    end
  endtask

  // Peak = first bin holding the largest power; energy = total power.
  function automatic void model(input bit skip, output longint pmag, output int pbin,
                                output longint en);
    longint m;
    pmag = 0;
    pbin = 0;
    en   = 0;
    for (int b = 0; b < N; b++) begin
      m  = longint'(fr_re[b]) * fr_re[b] + longint'(fr_im[b]) * fr_im[b];
      en = en + m;
      if (!(skip && b == 0) && m > pmag) begin
        pmag = m;
        pbin = b;
      end
    end
  endfunction

  // Entered and left just after a falling edge; transfers on the next rising edge.
  task automatic send_bin(input logic [31:0] d);
    int t = 0;
    drive(1'b1, d);
    while (bus0.o_data_ready !== 1'b1 && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("xfer_ready0", 64'(bus0.o_data_ready), 64'd1);
    chk("xfer_ready1", 64'(bus1.o_data_ready), 64'd1);
    @(negedge clk);
  endtask

  task automatic chk_out(input string name, input longint em0, input int eb0, input longint ee0,
                         input longint em1, input int eb1, input longint ee1);
    chk({name, ":bin0"}, 64'(bus0.o_peak_bin), 64'(eb0));
    chk({name, ":mag0"}, 64'(bus0.o_peak_mag), 64'(em0));
    chk({name, ":nrg0"}, 64'(bus0.o_energy),   64'(ee0));
    chk({name, ":bin1"}, 64'(bus1.o_peak_bin), 64'(eb1));
    chk({name, ":mag1"}, 64'(bus1.o_peak_mag), 64'(em1));
    chk({name, ":nrg1"}, 64'(bus1.o_energy),   64'(ee1));
  endtask

  task automatic run_frame(input string name, input bit hold, input bit gaps);
    longint em0, ee0, em1, ee1;
    int     eb0, eb1, m;
    model(1'b0, em0, eb0, ee0);
    model(1'b1, em1, eb1, ee1);
    for (int b = 0; b < N; b++) begin
      if (gaps && b > 0 && $urandom_range(0, 3) == 0) begin
        drive(1'b0, $urandom);
        repeat ($urandom_range(1, 3)) @(negedge clk);
      end
      send_bin({16'(fr_re[b]), 16'(fr_im[b])});
    end
    drive(1'b0, 32'h0);
    m = 0;
    chk({name, ":drain_ready"}, 64'(bus0.o_data_ready), 64'd0);
    while (bus0.o_data_valid !== 1'b1 && m < 20) begin
      @(negedge clk);
      m++;
    end
    chk({name, ":latency"}, 64'(m), 64'd3);
    chk({name, ":valid1"}, 64'(bus1.o_data_valid), 64'd1);
    chk({name, ":result_ready"}, 64'(bus0.o_data_ready), 64'd0);
    chk_out(name, em0, eb0, ee0, em1, eb1, ee1);
    if (hold) begin
      drive(1'b1, nxt0);
      for (int c = 0; c < 10; c++) begin
        @(negedge clk);
        chk({name, ":hold_valid"}, 64'(bus0.o_data_valid), 64'd1);
        chk({name, ":hold_ready"}, 64'(bus0.o_data_ready), 64'd0);
      end
      chk_out({name, ":held"}, em0, eb0, ee0, em1, eb1, ee1);
    end else begin
      repeat ($urandom_range(0, 4)) @(negedge clk);
    end
    set_ready(1'b1);
    @(negedge clk);
    set_ready(1'b0);
    chk({name, ":post_valid0"}, 64'(bus0.o_data_valid), 64'd0);
    chk({name, ":post_valid1"}, 64'(bus1.o_data_valid), 64'd0);
    chk({name, ":post_ready"},  64'(bus0.o_data_ready), 64'd1);
    chk({name, ":post_mag0"},   64'(bus0.o_peak_mag),   64'(em0));
    chk({name, ":post_nrg1"},   64'(bus1.o_energy),     64'(ee1));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    drive(1'b0, 32'h0);
    set_ready(1'b0);
    repeat (3) @(negedge clk);
    chk("rst:ready0", 64'(bus0.o_data_ready), 64'd0);
    chk("rst:valid0", 64'(bus0.o_data_valid), 64'd0);
    chk("rst:valid1", 64'(bus1.o_data_valid), 64'd0);
    chk("rst:bin0",   64'(bus0.o_peak_bin),   64'd0);
    chk("rst:mag0",   64'(bus0.o_peak_mag),   64'd0);
    chk("rst:nrg1",   64'(bus1.o_energy),     64'd0);
    rst = 1'b0;
    #1;
    chk("rst:ready_after", 64'(bus0.o_data_ready), 64'd1);
    @(negedge clk);

    fill(0, 0);
    fr_re[5] = 3; fr_im[5] = 4;
    run_frame("single", 1'b0, 1'b0);

    fill(0, 0);
    fr_re[2] = 1; fr_im[2] = -1;
    fr_re[6] = 1; fr_im[6] = -1;
    run_frame("tie", 1'b0, 1'b1);

    fill(1, 0);
    fr_re[10] = -32768; fr_im[10] = -32768;
    run_frame("maxmag", 1'b0, 1'b1);

    fill(0, 0);
    fr_re[0] = 100;
    fr_im[9] = 7;
    run_frame("dc", 1'b0, 1'b0);

    for (int b = 0; b < N; b++) begin
      fr_re[b] = int'($urandom_range(0, 8)) - 4;
      fr_im[b] = int'($urandom_range(0, 8)) - 4;
    end
    nxt0 = {16'd50, 16'd0};
    run_frame("hold", 1'b1, 1'b1);

    fill(1, 1);
    fr_re[0] = 50; fr_im[0] = 0;
    run_frame("after_hold", 1'b0, 1'b1);

    for (int b = 0; b < 30; b++) send_bin($urandom);
    rst = 1'b1;
    drive(1'b0, 32'h0);
    #1;
    chk("midrst:ready", 64'(bus0.o_data_ready), 64'd0);
    chk("midrst:valid", 64'(bus0.o_data_valid), 64'd0);
    @(negedge clk);
    chk("midrst:mag0", 64'(bus0.o_peak_mag), 64'd0);
    chk("midrst:nrg0", 64'(bus0.o_energy),   64'd0);
    chk("midrst:bin1", 64'(bus1.o_peak_bin), 64'd0);
    rst = 1'b0;
    #1;
    chk("midrst:ready_after", 64'(bus0.o_data_ready), 64'd1);
    @(negedge clk);
    fill(0, 0);
    fr_im[3] = 2;
    run_frame("post_rst", 1'b0, 1'b1);

    for (int f = 0; f < 4; f++) begin
      for (int b = 0; b < N; b++) begin
        if (f[0]) begin
          fr_re[b] = int'($urandom_range(0, 65535)) - 32768;
          fr_im[b] = int'($urandom_range(0, 65535)) - 32768;
        end else begin
          fr_re[b] = int'($urandom_range(0, 4)) - 2;
          fr_im[b] = int'($urandom_range(0, 4)) - 2;
        end
      end
      run_frame($sformatf("rand%0d", f), 1'b0, 1'b1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
